decode: RTL and testbench
=========================

# decode

Second stage of the five-stage RV32I pipeline, directly downstream of fetch. Holds the IF/ID pipeline register, splits the instruction into fields, generates the sign-extended immediate, and reads the 32×32 register file with write-back bypass. Detects load-use hazards and drives a stall back to fetch. Accepts a flush from execute on a taken branch or jump.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: value loaded into the ID PC register on reset and flush.
- `NOP`, 32'h0000_0013: instruction held in the ID register on reset, flush and bubble (`addi x0,x0,0`).

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `i_inst` input 32: instruction from fetch.
- `i_pc` input 32: PC of `i_inst`.
- `i_pc_inc` input 32: `i_pc`+4 from fetch.
- `i_flush` input 1: taken branch or jump in execute; kills the instruction in ID.
- `i_ex_mem_read` input 1: the instruction in execute is a load.
- `i_ex_rd` input 5: destination register of the instruction in execute.
- `i_wb_en` input 1: register-file write enable from write-back.
- `i_wb_rd` input 5: write-back destination register.
- `i_wb_data` input 32: write-back data.
- `o_stall` output 1: to fetch; hold the PC and do not advance.
- `o_valid` output 1: the ID outputs carry a real instruction this cycle.
- `o_pc`, `o_pc_inc` output 32: PC and PC+4 of the instruction in ID.
- `o_opcode` output 7, `o_funct3` output 3, `o_funct7` output 7: instruction fields.
- `o_rd`, `o_rs1`, `o_rs2` output 5: register indices.
- `o_rs1_data`, `o_rs2_data` output 32: register operands.
- `o_imm` output 32: sign-extended immediate.

## Operation
- ID register holds `id_inst`, `id_pc`, `id_pc_inc` and `id_valid`.
- Register update priority on each rising edge:
  - `i_flush`: load `NOP`, `RESET_PC`, `RESET_PC`+4, valid=0. Flush wins over stall.
  - else `o_stall`: hold all contents.
  - else capture `i_inst`, `i_pc`, `i_pc_inc`, valid=1.
- Register use:
  - rs1 is used by every opcode except LUI (0110111), AUIPC (0010111) and JAL (1101111).
  - rs2 is used only by R-type (0110011), S-type (0100011) and B-type (1100011).
- Hazard: `o_stall` = `id_valid` & `i_ex_mem_read` & (`i_ex_rd`≠0) & ((rs1 used & `i_ex_rd`==rs1) | (rs2 used & `i_ex_rd`==rs2)). Combinational.
- `o_valid` = `id_valid` & ~`o_stall`. A stall therefore emits one bubble into execute per stalled cycle.
- Immediate selection by opcode, all sign-extended from inst[31]:
  - I-type (0010011, 0000011, 1100111): inst[31:20].
  - S-type: {inst[31:25], inst[11:7]}.
  - B-type: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U-type: {inst[31:12], 12'b0}.
  - J-type: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - Any other opcode: 0.
- Register file:
  - 32 entries of 32 bits; x0 reads 0 and writes to x0 are discarded.
  - Write on the rising edge when `i_wb_en`=1 and `i_wb_rd`≠0.
  - Reads are combinational, write-first: if `i_wb_en`=1 and `i_wb_rd`==rsN and rsN≠0, the read returns `i_wb_data`.

## Timing
- Latency: one cycle from fetch outputs to the ID register. Decode outputs are combinational from the ID register and the register file.
- Reset (asserted low, asynchronous):
  - ID register = `NOP` / `RESET_PC` / `RESET_PC`+4, `id_valid`=0.
  - All 32 registers = 0.
  - Outputs during reset: `o_valid`=0, `o_stall`=0, `o_pc`=`RESET_PC`, `o_imm`=0, `o_rd`=0, operands=0.
  - Write-back writes during reset are ignored.
- Reset deassertion: the first clock edge after release captures fetch normally.
- Flush with stall in the same cycle: flush wins, and the stall drops the next cycle because `id_valid`=0.
- Write-back to rsN in the same cycle as a read: the bypassed value appears that cycle.
- A stall lasts exactly one cycle for a single load-use pair, since the load advances out of execute.

## Structure
- Shared package `riscv_pkg`:
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC);
  - `NOP` constant;
  - `imm_type_e` enum {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE}.
- One sub-module, `reg_file`: 2 read ports, 1 write port, bypass, asynchronous clear. Immediate generation and hazard logic stay inline.

## Test plan
- Reset low mid-run with `i_wb_en`=1 → `o_valid`=0, `o_pc`=0, register x5 reads 0 after release.
- `i_inst`=32'hFFF00093 (addi x1,x0,-1) → next cycle `o_imm`=32'hFFFFFFFF, `o_rd`=1, `o_valid`=1.
- Write x3=32'hDEADBEEF while `i_inst`=add x4,x3,x3 sits in ID → `o_rs1_data`=`o_rs2_data`=32'hDEADBEEF in the same cycle. A write to x0 keeps x0 reading 0.
- `i_ex_mem_read`=1, `i_ex_rd`=2, ID holds add x5,x2,x1 → `o_stall`=1 and `o_valid`=0 for one cycle, ID contents held. With `i_ex_rd`=2 against lui x2 in ID → no stall.
- Flush and stall asserted together → next cycle `o_valid`=0, `o_pc`=`RESET_PC`, `o_stall`=0.
- B-type inst 32'hFE000EE3 (beq x0,x0,-4) → `o_imm`=32'hFFFFFFFC.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I opcodes, NOP encoding and immediate-type helper
package riscv_pkg;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_e;
  function automatic imm_type_e imm_type(input logic [6:0] op);
    return (op == OP_IMM || op == LOAD || op == JALR) ? IMM_I :
           op == STORE ? IMM_S :
           op == BRANCH ? IMM_B :
           (op == LUI || op == AUIPC) ? IMM_U :
           op == JAL ? IMM_J : IMM_NONE;
  endfunction
endpackage

// File: rtl/decode_if.sv
// decode_if: fetch/execute/write-back inputs and decoded outputs of the ID stage
interface decode_if;
  logic [31:0] i_inst, i_pc, i_pc_inc;
  logic        i_flush, i_ex_mem_read;
  logic [4:0]  i_ex_rd;
  logic        i_wb_en;
  logic [4:0]  i_wb_rd;
  logic [31:0] i_wb_data;
  logic        o_stall, o_valid;
  logic [31:0] o_pc, o_pc_inc;
  logic [6:0]  o_opcode, o_funct7;
  logic [2:0]  o_funct3;
  logic [4:0]  o_rd, o_rs1, o_rs2;
  logic [31:0] o_rs1_data, o_rs2_data, o_imm;
  modport slave (
    input  i_inst, i_pc, i_pc_inc, i_flush, i_ex_mem_read, i_ex_rd, i_wb_en, i_wb_rd, i_wb_data,
    output o_stall, o_valid, o_pc, o_pc_inc, o_opcode, o_funct3, o_funct7, o_rd, o_rs1, o_rs2,
           o_rs1_data, o_rs2_data, o_imm
  );
  modport master (
    output i_inst, i_pc, i_pc_inc, i_flush, i_ex_mem_read, i_ex_rd, i_wb_en, i_wb_rd, i_wb_data,
    input  o_stall, o_valid, o_pc, o_pc_inc, o_opcode, o_funct3, o_funct7, o_rd, o_rs1, o_rs2,
           o_rs1_data, o_rs2_data, o_imm
  );
endinterface

// File: rtl/decode_reg_file.sv
// reg_file: 32x32 register file, x0 hardwired to zero, write-first bypass on both read ports
module reg_file (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] regs [32];
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (we && wa != 5'd0) regs[wa] <= wd;
  assign rd1 = ra1 == 5'd0 ? '0 : (we && wa == ra1) ? wd : regs[ra1];
  assign rd2 = ra2 == 5'd0 ? '0 : (we && wa == ra2) ? wd : regs[ra2];
endmodule

// File: rtl/decode.sv
// decode: RV32I ID stage - IF/ID register, field split, immediate, register read, load-use stall
module decode import riscv_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = riscv_pkg::NOP
) (
  input logic     clk,
  input logic     reset,
  decode_if.slave bus
);
  logic [31:0] id_inst, id_pc, id_pc_inc;
  logic        id_valid, rs1_used, rs2_used, stall;
  logic [6:0]  op;
  logic [4:0]  rs1, rs2;
  imm_type_e   it;
  assign op  = id_inst[6:0];
  assign rs1 = id_inst[19:15];
  assign rs2 = id_inst[24:20];
  assign it  = imm_type(op);
  always_ff @(posedge clk or negedge reset)
    if (!reset || bus.i_flush) begin
      id_inst   <= NOP;
      id_pc     <= RESET_PC;
      id_pc_inc <= RESET_PC + 32'd4;
      id_valid  <= 1'b0;
    end else if (!stall) begin
      id_inst   <= bus.i_inst;
      id_pc     <= bus.i_pc;
      id_pc_inc <= bus.i_pc_inc;
      id_valid  <= 1'b1;
    end
  always_comb begin
    rs1_used = !(op == LUI || op == AUIPC || op == JAL);
    rs2_used = op == OP || op == STORE || op == BRANCH;
    stall    = id_valid && bus.i_ex_mem_read && bus.i_ex_rd != 5'd0 &&
               ((rs1_used && bus.i_ex_rd == rs1) || (rs2_used && bus.i_ex_rd == rs2));
    bus.o_imm = it == IMM_I ? {{20{id_inst[31]}}, id_inst[31:20]} :
                it == IMM_S ? {{20{id_inst[31]}}, id_inst[31:25], id_inst[11:7]} :
                it == IMM_B ? {{20{id_inst[31]}}, id_inst[7], id_inst[30:25], id_inst[11:8], 1'b0} :
                it == IMM_U ? {id_inst[31:12], 12'b0} :
                it == IMM_J ? {{12{id_inst[31]}}, id_inst[19:12], id_inst[20], id_inst[30:21], 1'b0} :
                32'd0;
  end
  assign bus.o_stall  = stall;
  assign bus.o_valid  = id_valid && !stall;
  assign bus.o_pc     = id_pc;
  assign bus.o_pc_inc = id_pc_inc;
  assign bus.o_opcode = op;
  assign bus.o_funct3 = id_inst[14:12];
  assign bus.o_funct7 = id_inst[31:25];
  assign bus.o_rd     = id_inst[11:7];
  assign bus.o_rs1    = rs1;
  assign bus.o_rs2    = rs2;
  reg_file u_rf (
    .clk  (clk),
    .reset(reset),
    .we   (bus.i_wb_en),
    .wa   (bus.i_wb_rd),
    .wd   (bus.i_wb_data),
    .ra1  (rs1),
    .ra2  (rs2),
    .rd1  (bus.o_rs1_data),
    .rd2  (bus.o_rs2_data)
  );
endmodule

// File: tb/tb_decode.sv
// tb_decode: randomized + directed stimulus against a behavioural ID-stage model with a scoreboard
module tb_decode;
  import riscv_pkg::*;
  typedef struct {
    logic        stall, valid;
    logic [31:0] pc, pc_inc, rs1_data, rs2_data, imm;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0, failures = 0;
  exp_t q[$];
  logic [31:0] m_inst = 32'h13, m_pc = 32'h0, m_pc_inc = 32'h4;
  logic        m_valid = 1'b0;
  logic [31:0] m_regs [32];
  logic [6:0]  ops [10] = '{OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, 7'b1110011};
  decode_if dif();
  decode #(.RESET_PC(32'h0), .NOP(32'h13)) dut (.clk(clk), .reset(rst_n), .bus(dif.slave));
  always #5 clk = ~clk;
  function automatic logic [31:0] ref_imm(input logic [31:0] x);
    case (x[6:0])
      OP_IMM, LOAD, JALR: return 32'($signed(x[31:20]));
      STORE:              return 32'($signed({x[31:25], x[11:7]}));
      BRANCH:             return 32'($signed({x[31], x[7], x[30:25], x[11:8], 1'b0}));
      LUI, AUIPC:         return x[31:12] << 12;
      JAL:                return 32'($signed({x[31], x[19:12], x[20], x[30:21], 1'b0}));
      default:            return 32'd0;
    endcase
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask
  // One cycle: apply inputs at negedge, predict this cycle's outputs, then advance the model
  task automatic step(input logic rn, input logic [31:0] inst, input logic [31:0] pc, input logic fl,
                      input logic exr, input logic [4:0] exrd, input logic wben,
                      input logic [4:0] wbrd, input logic [31:0] wbd);
    exp_t e;
    logic [4:0] r1, r2;
    logic u1, u2;
    @(negedge clk);
    rst_n = rn;
    dif.i_inst = inst; dif.i_pc = pc; dif.i_pc_inc = pc + 32'd4; dif.i_flush = fl;
    dif.i_ex_mem_read = exr; dif.i_ex_rd = exrd;
    dif.i_wb_en = wben; dif.i_wb_rd = wbrd; dif.i_wb_data = wbd;
    if (!rn) begin
      m_inst = 32'h13; m_pc = 32'h0; m_pc_inc = 32'h4; m_valid = 1'b0;
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
    end
    #1;
    r1 = m_inst[19:15];
    r2 = m_inst[24:20];
    u1 = !(m_inst[6:0] inside {LUI, AUIPC, JAL});
    u2 = m_inst[6:0] inside {OP, STORE, BRANCH};
    e.stall = m_valid && exr && exrd != 0 && ((u1 && exrd == r1) || (u2 && exrd == r2));
    e.valid = m_valid && !e.stall;
    e.pc = m_pc; e.pc_inc = m_pc_inc;
    e.opcode = m_inst[6:0]; e.funct3 = m_inst[14:12]; e.funct7 = m_inst[31:25];
    e.rd = m_inst[11:7]; e.rs1 = r1; e.rs2 = r2;
    e.rs1_data = r1 == 0 ? 32'd0 : (wben && wbrd == r1) ? wbd : m_regs[r1];
    e.rs2_data = r2 == 0 ? 32'd0 : (wben && wbrd == r2) ? wbd : m_regs[r2];
    e.imm = ref_imm(m_inst);
    q.push_back(e);
    if (rn) begin
      if (wben && wbrd != 0) m_regs[wbrd] = wbd;
      if (fl) begin
        m_inst = 32'h13; m_pc = 32'h0; m_pc_inc = 32'h4; m_valid = 1'b0;
      end else if (!e.stall) begin
        m_inst = inst; m_pc = pc; m_pc_inc = pc + 32'd4; m_valid = 1'b1;
      end
    end
  endtask
  task automatic rand_step();
    logic [31:0] x;
    x = $urandom;
    x[6:0] = ops[$urandom_range(0, 9)];
    x[11:7] = 5'($urandom_range(0, 7));
    x[19:15] = 5'($urandom_range(0, 7));
    x[24:20] = 5'($urandom_range(0, 7));
    step(1'b1, x, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
         5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall", 32'(dif.o_stall), 32'(e.stall));
        chk("valid", 32'(dif.o_valid), 32'(e.valid));
        chk("pc", dif.o_pc, e.pc);
        chk("pc_inc", dif.o_pc_inc, e.pc_inc);
        chk("opcode", 32'(dif.o_opcode), 32'(e.opcode));
        chk("funct3", 32'(dif.o_funct3), 32'(e.funct3));
        chk("funct7", 32'(dif.o_funct7), 32'(e.funct7));
        chk("rd", 32'(dif.o_rd), 32'(e.rd));
        chk("rs1", 32'(dif.o_rs1), 32'(e.rs1));
        chk("rs2", 32'(dif.o_rs2), 32'(e.rs2));
        chk("rs1_data", dif.o_rs1_data, e.rs1_data);
        chk("rs2_data", dif.o_rs2_data, e.rs2_data);
        chk("imm", dif.o_imm, e.imm);
      end
    end
  end
  initial begin : driver
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    step(1'b0, 32'h13, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 32'h1234_5678);
    step(1'b0, 32'h13, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 32'h1234_5678);
    step(1'b1, 32'hFFF0_0093, 32'h100, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'h0031_8233, 32'h104, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'h0000_03B3, 32'h108, 1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 32'hDEAD_BEEF);
    step(1'b1, 32'h0011_02B3, 32'h10C, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    step(1'b1, 32'h0001_2137, 32'h110, 1'b0, 1'b1, 5'd2, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'h0001_2137, 32'h110, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'h0011_02B3, 32'h114, 1'b0, 1'b1, 5'd2, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'hFE00_0EE3, 32'h118, 1'b0, 1'b1, 5'd2, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'hFE00_0EE3, 32'h118, 1'b1, 1'b1, 5'd2, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'hFE00_0EE3, 32'h11C, 1'b0, 1'b1, 5'd2, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'h13, 32'h120, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 300; i++) rand_step();
    step(1'b1, 32'h0000_0013, 32'h200, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 32'hCAFE_0005);
    step(1'b0, 32'h0000_0013, 32'h204, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 32'h5555_5555);
    step(1'b0, 32'h0000_0013, 32'h204, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 32'h5555_5555);
    step(1'b1, 32'h0052_8333, 32'h208, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'h13, 32'h20C, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 50; i++) rand_step();
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
